// File: rtl/wb_arbiter_rr.sv
// wb_arbiter_rr: N-port Wishbone arbiter in front of one shared slave.
// Round-robin or fixed priority, with an optional stalled-cycle timeout.
module wb_arbiter_rr #(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 23,
    parameter int DATA_WIDTH     = 8,
    parameter int MODE           = 0,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_MASTERS-1:0]            wbs_cyc_i,
    input  logic [NUM_MASTERS-1:0]            wbs_stb_i,
    input  logic [NUM_MASTERS-1:0]            wbs_we_i,
    input  logic [NUM_MASTERS-1:0]            wbs_sel_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] wbs_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] wbs_dat_i,
    input  logic [NUM_MASTERS*3-1:0]          wbs_cti_i,
    input  logic [NUM_MASTERS*2-1:0]          wbs_bte_i,
    output logic [NUM_MASTERS-1:0]            wbs_ack_o,
    output logic [NUM_MASTERS-1:0]            wbs_err_o,
    output logic [NUM_MASTERS-1:0]            wbs_rty_o,
    output logic [DATA_WIDTH-1:0]             wbs_dat_o,
    output logic                              wbm_cyc_o,
    output logic                              wbm_stb_o,
    output logic                              wbm_we_o,
    output logic                              wbm_sel_o,
    output logic [ADDR_WIDTH-1:0]             wbm_adr_o,
    output logic [DATA_WIDTH-1:0]             wbm_dat_o,
    output logic [2:0]                        wbm_cti_o,
    output logic [1:0]                        wbm_bte_o,
    input  logic                              wbm_ack_i,
    input  logic                              wbm_err_i,
    input  logic                              wbm_rty_i,
    input  logic [DATA_WIDTH-1:0]             wbm_dat_i,
    output logic [NUM_MASTERS-1:0]            grant_o
);

    localparam int N  = NUM_MASTERS;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [TW-1:0] TMO_LAST =
        TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_ABORT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [TW-1:0]   tmo_q, tmo_d;

    logic            win_found;
    logic [IW-1:0]   win_idx;

    logic [N-1:0]    own_oh;
    logic            own_cyc;
    logic            own_stb;
    logic            own_we;
    logic            own_sel;
    logic [ADDR_WIDTH-1:0] own_adr;
    logic [DATA_WIDTH-1:0] own_dat;
    logic [2:0]      own_cti;
    logic [1:0]      own_bte;
    logic            own_resp;
    logic            tmo_hit;

    // Find the next owner among requesting masters
    always_comb begin
        int            scan;
        logic [IW-1:0] cand;
        scan      = 0;
        cand      = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (MODE == 1) begin
                scan = k;
            end else begin
                scan = (int'(ptr_q) + 1 + k) % N;
            end
            cand = IW'(scan);
            if (!win_found && wbs_cyc_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Select the current owner's request signals
    always_comb begin
        own_oh  = '0;
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_we  = 1'b0;
        own_sel = 1'b0;
        own_adr = '0;
        own_dat = '0;
        own_cti = '0;
        own_bte = '0;
        for (int i = 0; i < N; i++) begin
            if (owner_q == IW'(i)) begin
                own_oh[i] = 1'b1;
                own_cyc   = wbs_cyc_i[i];
                own_stb   = wbs_stb_i[i];
                own_we    = wbs_we_i[i];
                own_sel   = wbs_sel_i[i];
                own_adr   = wbs_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                own_dat   = wbs_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
                own_cti   = wbs_cti_i[i*3 +: 3];
                own_bte   = wbs_bte_i[i*2 +: 2];
            end
        end
    end

    // A stalled strobe that has waited its full budget aborts the cycle;
    // a response arriving on that very cycle still takes precedence
    always_comb begin
        own_resp = wbm_ack_i | wbm_err_i | wbm_rty_i;
        tmo_hit  = TMO_EN && own_stb && !own_resp
                   && (tmo_q == TMO_LAST);
    end

    // Next-state, bus steering and response routing
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        tmo_d     = '0;
        wbm_cyc_o = 1'b0;
        wbm_stb_o = 1'b0;
        wbm_we_o  = 1'b0;
        wbm_sel_o = 1'b0;
        wbm_adr_o = '0;
        wbm_dat_o = '0;
        wbm_cti_o = '0;
        wbm_bte_o = '0;
        wbs_ack_o = '0;
        wbs_err_o = '0;
        wbs_rty_o = '0;
        unique case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d = S_GRANT;
                    owner_d = win_idx;
                    if (MODE == 0) begin
                        ptr_d = win_idx;
                    end
                end
            end
            S_GRANT: begin
                if (!own_cyc) begin
                    state_d = S_IDLE;
                end else if (tmo_hit) begin
                    wbs_err_o = own_oh;
                    state_d   = S_ABORT;
                end else begin
                    wbm_cyc_o = 1'b1;
                    wbm_stb_o = own_stb;
                    wbm_we_o  = own_we;
                    wbm_sel_o = own_sel;
                    wbm_adr_o = own_adr;
                    wbm_dat_o = own_dat;
                    wbm_cti_o = own_cti;
                    wbm_bte_o = own_bte;
                    wbs_ack_o = own_oh & {N{wbm_ack_i}};
                    wbs_err_o = own_oh & {N{wbm_err_i}};
                    wbs_rty_o = own_oh & {N{wbm_rty_i}};
                    if (TMO_EN && own_stb && !own_resp) begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
            end
            S_ABORT: begin
                if (!own_cyc) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Grant is visible for as long as a master owns the bus
    always_comb begin
        grant_o = '0;
        if (state_q != S_IDLE) begin
            grant_o = own_oh;
        end
    end

    // Read data goes to every master; only the owner sees an ack
    assign wbs_dat_o = wbm_dat_i;

    // Arbiter state and current owner
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // Round-robin pointer, starts so that master 0 is searched first
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= IW'(N - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Stall counter for the response timeout
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

endmodule
